jt51_acc_mix: RTL and testbench
===============================

Name: jt51_acc_mix

Overview:
- Output accumulator directly downstream of the pipelined operator.
- Takes one signed 14-bit operator result per cen slot (32 slots per frame: 4 operator groups × 8 channels) and keeps only the carrier operators for each channel's connection algorithm.
- Sums carriers per channel, routes each channel total to left/right by the channel's RL enables, and emits one saturated 16-bit stereo sample per frame.

Parameters:
- none

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low (asserted when 0)
- cen  in  1  clock enable, one operator slot per high cycle
- zero  in  1  qualified by cen; marks that op_result belongs to slot 0
- op_result  in  14  signed operator output for the current slot
- con  in  3  connection algorithm of the current slot's channel; caller aligns it to op_result
- rl  in  2  channel output enables for the current slot; [1]=right, [0]=left; aligned like con
- left  out  16  signed left sample
- right  out  16  signed right sample
- sample  out  1  high for one cen period when left/right update

Behaviour:
- Reset (rst=0, asynchronous):
  - left=0, right=0, sample=0.
  - Slot counter=0, synced=0.
  - All channel and mix accumulators cleared.
- All state changes happen only on clk edges with cen=1.
- Slot counter (5 bits):
  - On cen with zero=1: the current input is treated as slot 0, synced is set to 1, and the counter advances to 1.
  - Otherwise the counter increments modulo 32.
- Slot decoding: group = slot[4:3] (0=M1, 1=M2, 2=C1, 3=C2); channel = slot[2:0].
- Carrier table (is_carrier):
  - con 0–3: C2 only.
  - con 4: C1, C2.
  - con 5–6: M2, C1, C2.
  - con 7: M1, M2, C1, C2.
- Contribution: v = is_carrier ? sign-extended op_result : 0.
- Channel accumulators: 8 × 16-bit signed, indexed by channel.
  - M1 slot: chacc[ch] <= v (restart, old value discarded).
  - M2 or C1 slot: chacc[ch] <= chacc[ch] + v. Four 14-bit terms cannot overflow 16 bits.
  - C2 slot: total = chacc[ch] + v, not stored.
- Mix: two 19-bit signed accumulators, mixl and mixr.
  - On C2 slots, mixl adds total if rl[0] is set, else adds 0; mixr likewise with rl[1].
  - On the C2 slot of channel 0 (slot 24), the mix is loaded rather than added, which restarts the frame sum.
- Output at slot 31 (C2, ch7) with synced=1:
  - Final sums including slot 31 are saturated to 16 bits (clamped to 32767 / -32768).
  - Results are registered into left/right on that edge.
  - sample goes high on that edge and falls at the next cen edge.
  - Latency: 1 cen from slot-31 input to output.
- Resync: zero=1 arriving when the counter is not 0:
  - Counter forced to 0 as above.
  - The partial frame is discarded; mix is reloaded at the next slot 24.
  - No sample pulse for the broken frame; left/right hold their previous values.
- Before the first zero after reset: no sample pulses and outputs stay 0.
- cen=0: all state and outputs hold; sample stays at its current level.
- Reset mid-frame: everything cleared; output resumes only after the next zero and a complete slot 24–31 span.

Test Plan:
- Reset with rst=0 mid-stream -> left=right=0, sample=0 immediately (asynchronous), no pulse until the frame after the next zero.
- con=7 on ch0, all four ops=1000, rl=2'b11, others 0 -> left=right=4000, one sample pulse 1 cen after slot 31.
- con=0 on ch3, M1/M2/C1=5000, C2=-200, rl=2'b01 -> left=-200, right=0.
- All 8 channels con=7, every op=8191, rl=2'b11 -> left=right=32767 (saturated); all ops=-8192 -> -32768.
- con=4 on ch5, C1=300, C2=-100, rl=2'b10 -> left=0, right=200; next frame ch5 all 0 -> right=0 (M1 restart clears the channel).
- zero pulsed at slot 17 -> no sample pulse for the broken frame, outputs hold, next full frame outputs correctly; with cen held low for 10 clocks mid-frame the results are identical.

Source files
------------

// File: rtl/jt51_acc_mix.sv
// Output accumulator for the jt51 operator pipeline: keeps carrier operators,
// sums them per channel, routes them by RL and emits a saturated stereo sample per frame.
module jt51_acc_mix (
   input  logic        clk,
   input  logic        rst,
   input  logic        cen,
   input  logic        zero,
   input  logic [13:0] op_result,
   input  logic [2:0]  con,
   input  logic [1:0]  rl,
   output logic [15:0] left,
   output logic [15:0] right,
   output logic        sample
);

   localparam logic [1:0] GRP_M1 = 2'd0;
   localparam logic [1:0] GRP_M2 = 2'd1;
   localparam logic [1:0] GRP_C1 = 2'd2;
   localparam logic [1:0] GRP_C2 = 2'd3;

   localparam logic signed [18:0] SAT_MAX = 19'sd32767;
   localparam logic signed [18:0] SAT_MIN = -19'sd32768;

   logic [4:0]         cnt;
   logic               synced;
   logic [4:0]         slot;
   logic [1:0]         grp;
   logic [2:0]         ch;
   logic               carrier;
   logic signed [15:0] v;
   logic signed [15:0] total;
   logic signed [15:0] chacc [8];
   logic signed [18:0] mixl;
   logic signed [18:0] mixr;
   logic signed [18:0] addl;
   logic signed [18:0] addr;
   logic signed [18:0] suml;
   logic signed [18:0] sumr;
   logic [15:0]        satl;
   logic [15:0]        satr;
   logic               frame_end;

   // zero overrides the counter so the current input is already treated as slot 0
   always_comb begin
      slot = zero ? 5'd0 : cnt;
      grp  = slot[4:3];
      ch   = slot[2:0];
   end

   always_comb begin
      carrier = 1'b0;
      case (grp)
         GRP_M1:  carrier = (con == 3'd7);
         GRP_M2:  carrier = (con >= 3'd5);
         GRP_C1:  carrier = (con >= 3'd4);
         GRP_C2:  carrier = 1'b1;
         default: carrier = 1'b0;
      endcase
   end

   always_comb begin
      v     = carrier ? {{2{op_result[13]}}, op_result} : 16'sd0;
      total = chacc[ch] + v;
      addl  = rl[0] ? {{3{total[15]}}, total} : 19'sd0;
      addr  = rl[1] ? {{3{total[15]}}, total} : 19'sd0;
      // slot 24 is the first C2 of the frame: restart the mix instead of adding
      suml  = (slot == 5'd24) ? addl : mixl + addl;
      sumr  = (slot == 5'd24) ? addr : mixr + addr;
   end

   always_comb begin
      if (suml > SAT_MAX)
         satl = 16'h7fff;
      else if (suml < SAT_MIN)
         satl = 16'h8000;
      else
         satl = suml[15:0];
      if (sumr > SAT_MAX)
         satr = 16'h7fff;
      else if (sumr < SAT_MIN)
         satr = 16'h8000;
      else
         satr = sumr[15:0];
   end

   assign frame_end = synced && (slot == 5'd31);

   // A resync simply restarts the count; the broken frame never reaches slot 31,
   // and the new frame always passes slot 24 before its own slot 31.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt    <= '0;
         synced <= 1'b0;
      end else if (cen) begin
         cnt <= slot + 5'd1;
         if (zero)
            synced <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < 8; i++)
            chacc[i] <= '0;
      end else if (cen) begin
         case (grp)
            GRP_M1:  chacc[ch] <= v;
            GRP_M2:  chacc[ch] <= total;
            GRP_C1:  chacc[ch] <= total;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mixl <= '0;
         mixr <= '0;
      end else if (cen && grp == GRP_C2) begin
         mixl <= suml;
         mixr <= sumr;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         left   <= '0;
         right  <= '0;
         sample <= 1'b0;
      end else if (cen) begin
         sample <= frame_end;
         if (frame_end) begin
            left  <= satl;
            right <= satr;
         end
      end
   end

endmodule

// File: tb/tb_jt51_acc_mix.sv
// Self-checking bench for jt51_acc_mix: directed frames plus randomized frames
// compared against a per-frame arithmetic model of the carrier/mix rules.
module tb_jt51_acc_mix;

   logic        clk = 1'b0;
   logic        rst;
   logic        cen;
   logic        zero;
   logic [13:0] op_result;
   logic [2:0]  con;
   logic [1:0]  rl;
   logic [15:0] left;
   logic [15:0] right;
   logic        sample;

   int n_cmp = 0;
   int n_bad = 0;

   logic signed [13:0] ops [32];
   logic [2:0]         ch_con [8];
   logic [1:0]         ch_rl [8];
   logic [15:0]        cur_l = '0;
   logic [15:0]        cur_r = '0;

   jt51_acc_mix dut (
      .clk       (clk),
      .rst       (rst),
      .cen       (cen),
      .zero      (zero),
      .op_result (op_result),
      .con       (con),
      .rl        (rl),
      .left      (left),
      .right     (right),
      .sample    (sample)
   );

   always #5 clk = ~clk;

   // number of carriers per algorithm; carriers are always the last groups (C2, C1, M2, M1)
   function automatic int ncarr(input logic [2:0] c);
      if (c < 3'd4) return 1;
      if (c == 3'd4) return 2;
      if (c < 3'd7) return 3;
      return 4;
   endfunction

   function automatic int sat16(input int x);
      if (x > 32767) return 32767;
      if (x < -32768) return -32768;
      return x;
   endfunction

   task automatic model(output logic [15:0] l, output logic [15:0] r);
      int sl, sr, tot, t;
      sl = 0;
      sr = 0;
      for (int c = 0; c < 8; c++) begin
         tot = 0;
         for (int g = 0; g < 4; g++)
            if (g >= 4 - ncarr(ch_con[c])) tot += int'(ops[g*8 + c]);
         if (ch_rl[c][0]) sl += tot;
         if (ch_rl[c][1]) sr += tot;
      end
      t = sat16(sl);
      l = t[15:0];
      t = sat16(sr);
      r = t[15:0];
   endtask

   task automatic clear_frame();
      for (int i = 0; i < 32; i++) ops[i] = '0;
      for (int c = 0; c < 8; c++) begin
         ch_con[c] = '0;
         ch_rl[c]  = '0;
      end
   endtask

   task automatic rand_frame();
      for (int i = 0; i < 32; i++) ops[i] = 14'($urandom_range(0, 16383));
      for (int c = 0; c < 8; c++) begin
         ch_con[c] = 3'($urandom_range(0, 7));
         ch_rl[c]  = 2'($urandom_range(0, 3));
      end
   endtask

   // Drives nslots slots (zero on slot 0 when z), optionally idling cen for gap_len
   // clocks before slot gap_at. Reports observations only; the tests judge them.
   task automatic run_frame(input bit z, input int nslots, input int gap_at, input int gap_len,
                            input logic [15:0] hold_l, input logic [15:0] hold_r,
                            output int early, output int hold_bad,
                            output logic s31, output logic [15:0] l31, output logic [15:0] r31);
      early    = 0;
      hold_bad = 0;
      s31      = 1'b0;
      l31      = left;
      r31      = right;
      for (int s = 0; s < nslots; s++) begin
         if (s == gap_at) begin
            cen = 1'b0;
            repeat (gap_len) @(posedge clk);
            #1;
         end
         zero      = z && (s == 0);
         op_result = ops[s];
         con       = ch_con[s % 8];
         rl        = ch_rl[s % 8];
         cen       = 1'b1;
         @(posedge clk);
         #1;
         cen  = 1'b0;
         zero = 1'b0;
         if (s == 31) begin
            s31 = sample;
            l31 = left;
            r31 = right;
         end else begin
            if (sample) early++;
            if (left !== hold_l || right !== hold_r) hold_bad++;
         end
      end
   endtask

   task automatic test_reset();
      int e, hb;
      logic s;
      logic [15:0] l, r;
      rst = 1'b0; cen = 1'b0; zero = 1'b0; op_result = '0; con = '0; rl = '0;
      #3;
      n_cmp++;
      if (left !== 16'd0 || right !== 16'd0 || sample !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_state: got l=%0d r=%0d s=%b, want 0 0 0", $signed(left), $signed(right), sample);
      end
      #10 rst = 1'b1;
      @(posedge clk); #1;
      rand_frame();
      run_frame(1'b0, 32, -1, 0, 16'd0, 16'd0, e, hb, s, l, r);
      n_cmp++;
      if (s !== 1'b0 || e != 0 || hb != 0 || l !== 16'd0 || r !== 16'd0) begin
         n_bad++;
         $display("FAIL unsynced_frame: got s31=%b pulses=%0d holdbad=%0d l=%0d r=%0d, want 0 0 0 0 0",
                  s, e, hb, $signed(l), $signed(r));
      end
   endtask

   task automatic test_con7();
      int e, hb;
      logic s;
      logic [15:0] l, r;
      clear_frame();
      ch_con[0] = 3'd7; ch_rl[0] = 2'b11;
      ops[0] = 14'sd1000; ops[8] = 14'sd1000; ops[16] = 14'sd1000; ops[24] = 14'sd1000;
      run_frame(1'b1, 32, -1, 0, cur_l, cur_r, e, hb, s, l, r);
      n_cmp++;
      if (s !== 1'b1 || e != 0 || hb != 0) begin
         n_bad++;
         $display("FAIL con7_pulse: got s31=%b pulses=%0d holdbad=%0d, want 1 0 0", s, e, hb);
      end
      n_cmp++;
      if (l !== 16'd4000 || r !== 16'd4000) begin
         n_bad++;
         $display("FAIL con7_value: got l=%0d r=%0d, want 4000 4000", $signed(l), $signed(r));
      end
      cur_l = 16'd4000; cur_r = 16'd4000;
   endtask

   task automatic test_con0();
      int e, hb;
      logic s;
      logic [15:0] l, r;
      clear_frame();
      ch_con[3] = 3'd0; ch_rl[3] = 2'b01;
      ops[3] = 14'sd5000; ops[11] = 14'sd5000; ops[19] = 14'sd5000; ops[27] = -14'sd200;
      run_frame(1'b1, 32, -1, 0, cur_l, cur_r, e, hb, s, l, r);
      n_cmp++;
      if (s !== 1'b1 || e != 0 || hb != 0 || l !== 16'hff38 || r !== 16'd0) begin
         n_bad++;
         $display("FAIL con0_ch3: got s31=%b pulses=%0d holdbad=%0d l=%0d r=%0d, want 1 0 0 -200 0",
                  s, e, hb, $signed(l), $signed(r));
      end
      cur_l = 16'hff38; cur_r = 16'd0;
   endtask

   task automatic test_saturate();
      int e, hb;
      logic s;
      logic [15:0] l, r;
      for (int c = 0; c < 8; c++) begin ch_con[c] = 3'd7; ch_rl[c] = 2'b11; end
      for (int i = 0; i < 32; i++) ops[i] = 14'sd8191;
      run_frame(1'b1, 32, -1, 0, cur_l, cur_r, e, hb, s, l, r);
      n_cmp++;
      if (s !== 1'b1 || l !== 16'h7fff || r !== 16'h7fff) begin
         n_bad++;
         $display("FAIL sat_pos: got s31=%b l=%0d r=%0d, want 1 32767 32767", s, $signed(l), $signed(r));
      end
      for (int i = 0; i < 32; i++) ops[i] = -14'sd8192;
      run_frame(1'b1, 32, -1, 0, 16'h7fff, 16'h7fff, e, hb, s, l, r);
      n_cmp++;
      if (s !== 1'b1 || e != 0 || hb != 0 || l !== 16'h8000 || r !== 16'h8000) begin
         n_bad++;
         $display("FAIL sat_neg: got s31=%b pulses=%0d holdbad=%0d l=%0d r=%0d, want 1 0 0 -32768 -32768",
                  s, e, hb, $signed(l), $signed(r));
      end
      cur_l = 16'h8000; cur_r = 16'h8000;
   endtask

   task automatic test_con4_restart();
      int e, hb;
      logic s;
      logic [15:0] l, r;
      clear_frame();
      ch_con[5] = 3'd4; ch_rl[5] = 2'b10;
      ops[5] = 14'sd777; ops[13] = 14'sd555;
      ops[21] = 14'sd300; ops[29] = -14'sd100;
      run_frame(1'b1, 32, -1, 0, cur_l, cur_r, e, hb, s, l, r);
      n_cmp++;
      if (s !== 1'b1 || l !== 16'd0 || r !== 16'd200) begin
         n_bad++;
         $display("FAIL con4_ch5: got s31=%b l=%0d r=%0d, want 1 0 200", s, $signed(l), $signed(r));
      end
      for (int i = 0; i < 32; i++) ops[i] = '0;
      run_frame(1'b1, 32, -1, 0, 16'd0, 16'd200, e, hb, s, l, r);
      n_cmp++;
      if (s !== 1'b1 || e != 0 || hb != 0 || l !== 16'd0 || r !== 16'd0) begin
         n_bad++;
         $display("FAIL m1_restart: got s31=%b pulses=%0d holdbad=%0d l=%0d r=%0d, want 1 0 0 0 0",
                  s, e, hb, $signed(l), $signed(r));
      end
      cur_l = 16'd0; cur_r = 16'd0;
   endtask

   task automatic test_resync();
      int e, hb;
      logic s;
      logic [15:0] l, r, el, er;
      rand_frame();
      run_frame(1'b1, 17, -1, 0, cur_l, cur_r, e, hb, s, l, r);
      n_cmp++;
      if (e != 0 || hb != 0) begin
         n_bad++;
         $display("FAIL broken_frame: got pulses=%0d holdbad=%0d, want 0 0", e, hb);
      end
      rand_frame();
      model(el, er);
      run_frame(1'b1, 32, 20, 10, cur_l, cur_r, e, hb, s, l, r);
      n_cmp++;
      if (s !== 1'b1 || e != 0 || hb != 0 || l !== el || r !== er) begin
         n_bad++;
         $display("FAIL resync_gap: got s31=%b pulses=%0d holdbad=%0d l=%0d r=%0d, want 1 0 0 %0d %0d",
                  s, e, hb, $signed(l), $signed(r), $signed(el), $signed(er));
      end
      run_frame(1'b1, 32, -1, 0, el, er, e, hb, s, l, r);
      n_cmp++;
      if (s !== 1'b1 || e != 0 || hb != 0 || l !== el || r !== er) begin
         n_bad++;
         $display("FAIL resync_nogap: got s31=%b pulses=%0d holdbad=%0d l=%0d r=%0d, want 1 0 0 %0d %0d",
                  s, e, hb, $signed(l), $signed(r), $signed(el), $signed(er));
      end
      cur_l = el; cur_r = er;
   endtask

   task automatic test_reset_mid();
      int e, hb;
      logic s;
      logic [15:0] l, r, el, er;
      clear_frame();
      ch_con[2] = 3'd7; ch_rl[2] = 2'b11;
      ops[2] = 14'sd1234;
      run_frame(1'b1, 32, -1, 0, cur_l, cur_r, e, hb, s, l, r);
      run_frame(1'b1, 10, -1, 0, 16'd1234, 16'd1234, e, hb, s, l, r);
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if (left !== 16'd0 || right !== 16'd0 || sample !== 1'b0) begin
         n_bad++;
         $display("FAIL async_reset: got l=%0d r=%0d s=%b, want 0 0 0", $signed(left), $signed(right), sample);
      end
      #2 rst = 1'b1;
      @(posedge clk); #1;
      rand_frame();
      run_frame(1'b0, 32, -1, 0, 16'd0, 16'd0, e, hb, s, l, r);
      n_cmp++;
      if (s !== 1'b0 || e != 0 || hb != 0 || l !== 16'd0 || r !== 16'd0) begin
         n_bad++;
         $display("FAIL post_reset_nozero: got s31=%b pulses=%0d holdbad=%0d l=%0d r=%0d, want 0 0 0 0 0",
                  s, e, hb, $signed(l), $signed(r));
      end
      rand_frame();
      model(el, er);
      run_frame(1'b1, 32, -1, 0, 16'd0, 16'd0, e, hb, s, l, r);
      n_cmp++;
      if (s !== 1'b1 || e != 0 || hb != 0 || l !== el || r !== er) begin
         n_bad++;
         $display("FAIL post_reset_frame: got s31=%b pulses=%0d holdbad=%0d l=%0d r=%0d, want 1 0 0 %0d %0d",
                  s, e, hb, $signed(l), $signed(r), $signed(el), $signed(er));
      end
      cur_l = el; cur_r = er;
   endtask

   task automatic test_random();
      int e, hb, gap_at, gap_len;
      bit z;
      logic s;
      logic [15:0] l, r, el, er;
      for (int f = 0; f < 24; f++) begin
         rand_frame();
         model(el, er);
         z       = ($urandom_range(0, 3) != 0);
         gap_at  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 31)) : -1;
         gap_len = int'($urandom_range(1, 4));
         run_frame(z, 32, gap_at, gap_len, cur_l, cur_r, e, hb, s, l, r);
         n_cmp++;
         if (s !== 1'b1 || e != 0 || hb != 0 || l !== el || r !== er) begin
            n_bad++;
            $display("FAIL random_frame%0d: got s31=%b pulses=%0d holdbad=%0d l=%0d r=%0d, want 1 0 0 %0d %0d",
                     f, s, e, hb, $signed(l), $signed(r), $signed(el), $signed(er));
         end
         cur_l = el; cur_r = er;
      end
      cen = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (sample !== 1'b1 || left !== cur_l || right !== cur_r) begin
         n_bad++;
         $display("FAIL cen_low_hold: got s=%b l=%0d r=%0d, want 1 %0d %0d",
                  sample, $signed(left), $signed(right), $signed(cur_l), $signed(cur_r));
      end
   endtask

   initial begin
      test_reset();
      test_con7();
      test_con0();
      test_saturate();
      test_con4_restart();
      test_resync();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
